// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: EX/MEM control-bit positions and MEM-stage FSM states.
package mips_pkg;

  localparam int unsigned CTR_W        = 5;
  localparam int unsigned CTR_BRANCH   = 4;
  localparam int unsigned CTR_MEMREAD  = 3;
  localparam int unsigned CTR_MEMWRITE = 2;
  localparam int unsigned CTR_REGWRITE = 1;
  localparam int unsigned CTR_MEMTOREG = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: a bubble (or reset) clears every field; otherwise load captures the inputs.
module mem_wb_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_bubble,
  input  logic [1:0]        i_ctr,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [REG_W-1:0]  i_reg,
  output logic [1:0]        o_ctr,
  output logic [DATA_W-1:0] o_rdata,
  output logic [DATA_W-1:0] o_alu,
  output logic [REG_W-1:0]  o_reg
);

  logic [1:0]        r_ctr;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_alu;
  logic [REG_W-1:0]  r_reg;

  always_ff @(posedge clock) begin
    if (reset || i_bubble) begin
      r_ctr   <= '0;
      r_rdata <= '0;
      r_alu   <= '0;
      r_reg   <= '0;
    end else if (i_load) begin
      r_ctr   <= i_ctr;
      r_rdata <= i_rdata;
      r_alu   <= i_alu;
      r_reg   <= i_reg;
    end
  end

  assign o_ctr   = r_ctr;
  assign o_rdata = r_rdata;
  assign o_alu   = r_alu;
  assign o_reg   = r_reg;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data-memory req/ready access with pipeline stall, branch resolve, MEM/WB drive.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses are dropped and flagged on align_fault.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CTR_W-1:0]  ctr_bits,
  input  logic [DATA_W-1:0] add_result,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [REG_W-1:0]  write_reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall,
  output logic              pcsrc,
  output logic [DATA_W-1:0] branch_target,
  output logic              align_fault,
  output logic [1:0]        wb_ctr,
  output logic [DATA_W-1:0] wb_rdata,
  output logic [DATA_W-1:0] wb_alu,
  output logic [REG_W-1:0]  wb_reg
);

  mem_state_t        r_state;
  logic              r_req;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_align_fault;

  logic              w_memop;
  logic              w_misaligned;
  logic              w_issue;
  logic [DATA_W-1:0] w_addr;
  logic              w_wb_load;
  logic              w_wb_bubble;
  logic [DATA_W-1:0] w_wb_rdata;

  assign w_memop = ctr_bits[CTR_MEMREAD] | ctr_bits[CTR_MEMWRITE];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = |alu_result[1:0];
  assign w_addr       = alu_result;
`else
  assign w_misaligned = 1'b0;
  assign w_addr       = {alu_result[DATA_W-1:2], 2'b00};
`endif

  assign w_issue = (r_state == IDLE) && w_memop && !w_misaligned;

  // Stall and MEM/WB write selection for the current state
  always_comb begin
    stall       = 1'b0;
    w_wb_load   = 1'b0;
    w_wb_bubble = 1'b0;
    w_wb_rdata  = '0;
    unique case (r_state)
      IDLE: begin
        stall = w_issue;
        if (w_memop) w_wb_bubble = 1'b1;
        else         w_wb_load   = 1'b1;
      end
      WAIT: begin
        stall       = 1'b1;
        w_wb_bubble = 1'b1;
      end
      DONE: begin
        w_wb_load  = 1'b1;
        w_wb_rdata = r_rdata;
      end
      default: w_wb_bubble = 1'b1;
    endcase
  end

  // Access FSM; a reset while waiting simply abandons the request
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_align_fault <= 1'b0;
    end else begin
      r_align_fault <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state <= WAIT;
            r_req   <= 1'b1;
            r_we    <= ctr_bits[CTR_MEMWRITE];
            r_addr  <= w_addr;
            r_wdata <= rdata2;
          end else if (w_memop && w_misaligned) begin
            r_align_fault <= 1'b1;
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_rdata <= r_we ? '0 : dmem_rdata;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_wb_load),
    .i_bubble (w_wb_bubble),
    .i_ctr    ({ctr_bits[CTR_REGWRITE], ctr_bits[CTR_MEMTOREG]}),
    .i_rdata  (w_wb_rdata),
    .i_alu    (alu_result),
    .i_reg    (write_reg),
    .o_ctr    (wb_ctr),
    .o_rdata  (wb_rdata),
    .o_alu    (wb_alu),
    .o_reg    (wb_reg)
  );

  assign dmem_req      = r_req;
  assign dmem_we       = r_we;
  assign dmem_addr     = r_addr;
  assign dmem_wdata    = r_wdata;
  assign align_fault   = r_align_fault;
  assign pcsrc         = ctr_bits[CTR_BRANCH] & zero;
  assign branch_target = add_result;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: per-cycle timeline model of stall/request/MEM-WB plus literal pins.
module tb_mem_access_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic [4:0]        ctr_bits;
  logic [DATA_W-1:0] add_result;
  logic              zero;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] rdata2;
  logic [REG_W-1:0]  write_reg;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;
  logic              stall;
  logic              pcsrc;
  logic [DATA_W-1:0] branch_target;
  logic              align_fault;
  logic [1:0]        wb_ctr;
  logic [DATA_W-1:0] wb_rdata;
  logic [DATA_W-1:0] wb_alu;
  logic [REG_W-1:0]  wb_reg;

  mem_access_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctr_bits      (ctr_bits),
    .add_result    (add_result),
    .zero          (zero),
    .alu_result    (alu_result),
    .rdata2        (rdata2),
    .write_reg     (write_reg),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ready    (dmem_ready),
    .stall         (stall),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .align_fault   (align_fault),
    .wb_ctr        (wb_ctr),
    .wb_rdata      (wb_rdata),
    .wb_alu        (wb_alu),
    .wb_reg        (wb_reg)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Model of what MEM/WB and align_fault must hold after the most recent edge
  logic [1:0]        m_wb_ctr   = '0;
  logic [DATA_W-1:0] m_wb_rdata = '0;
  logic [DATA_W-1:0] m_wb_alu   = '0;
  logic [REG_W-1:0]  m_wb_reg   = '0;
  logic              m_fault    = 1'b0;

  // Observations gathered over one instruction
  int                stall_cycles;
  int                req_cycles;
  logic              seen_we;
  logic [DATA_W-1:0] seen_addr;
  logic [DATA_W-1:0] seen_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at the falling edge, then advance the model across the rising edge
  task automatic cycle(input logic e_stall, input logic e_req, input logic e_we,
                       input logic [DATA_W-1:0] e_addr, input logic [DATA_W-1:0] e_wdata,
                       input logic [1:0] n_ctr, input logic [DATA_W-1:0] n_rdata,
                       input logic [DATA_W-1:0] n_alu, input logic [REG_W-1:0] n_reg,
                       input logic n_fault);
    @(negedge clock);
    chk("stall", 32'(stall), 32'(e_stall));
    chk("dmem_req", 32'(dmem_req), 32'(e_req));
    if (e_req) begin
      chk("dmem_we", 32'(dmem_we), 32'(e_we));
      chk("dmem_addr", dmem_addr, e_addr);
      chk("dmem_wdata", dmem_wdata, e_wdata);
    end
    chk("pcsrc", 32'(pcsrc), 32'(ctr_bits[4] & zero));
    chk("branch_target", branch_target, add_result);
    chk("wb_ctr", 32'(wb_ctr), 32'(m_wb_ctr));
    chk("wb_rdata", wb_rdata, m_wb_rdata);
    chk("wb_alu", wb_alu, m_wb_alu);
    chk("wb_reg", 32'(wb_reg), 32'(m_wb_reg));
    chk("align_fault", 32'(align_fault), 32'(m_fault));
    if (stall) stall_cycles++;
    if (dmem_req) begin
      req_cycles++;
      seen_we    = dmem_we;
      seen_addr  = dmem_addr;
      seen_wdata = dmem_wdata;
    end
    @(posedge clock);
    if (reset) begin
      m_wb_ctr = '0; m_wb_rdata = '0; m_wb_alu = '0; m_wb_reg = '0; m_fault = 1'b0;
    end else begin
      m_wb_ctr = n_ctr; m_wb_rdata = n_rdata; m_wb_alu = n_alu; m_wb_reg = n_reg; m_fault = n_fault;
    end
    #1;
  endtask

  // Holds one instruction in EX/MEM for as long as the timing rules say it must stay there
  task automatic run_instr(input logic [4:0] c, input logic [DATA_W-1:0] alu,
                           input logic [REG_W-1:0] wr, input logic [DATA_W-1:0] rd2,
                           input int n_wait, input logic [DATA_W-1:0] rdv);
    logic              memop;
    logic              is_wr;
    logic              mis;
    logic [DATA_W-1:0] e_addr;
    logic [DATA_W-1:0] cap;
    ctr_bits = c; alu_result = alu; write_reg = wr; rdata2 = rd2;
    dmem_ready = 1'b0; dmem_rdata = '0;
    memop = c[3] | c[2];
    is_wr = c[2];
`ifdef MEM_ALIGN_CHECK_EN
    mis    = (alu[1:0] != 2'b00);
    e_addr = alu;
`else
    mis    = 1'b0;
    e_addr = alu & 32'hFFFF_FFFC;
`endif
    stall_cycles = 0; req_cycles = 0;
    seen_we = 1'b0; seen_addr = '0; seen_wdata = '0;
    if (!memop) begin
      cycle(1'b0, 1'b0, 1'b0, '0, '0, c[1:0], '0, alu, wr, 1'b0);
    end else if (mis) begin
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, '0, '0, '0, 1'b1);
    end else begin
      // ready while no request is outstanding must be ignored
      dmem_ready = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 2'b00, '0, '0, '0, 1'b0);
      for (int i = 1; i <= n_wait; i++) begin
        dmem_ready = (i == n_wait);
        dmem_rdata = (i == n_wait) ? rdv : 32'h5A5A_5A5A;
        cycle(1'b1, 1'b1, is_wr, e_addr, rd2, 2'b00, '0, '0, '0, 1'b0);
      end
      dmem_ready = 1'b0; dmem_rdata = 32'h1111_2222;
      cap = is_wr ? '0 : rdv;
      cycle(1'b0, 1'b0, 1'b0, '0, '0, c[1:0], cap, alu, wr, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; ctr_bits = '0; add_result = '0; zero = 1'b0; alu_result = '0;
    rdata2 = '0; write_reg = '0; dmem_rdata = '0; dmem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_align_fault", 32'(align_fault), 32'd0);
    chk("rst_wb_ctr", 32'(wb_ctr), 32'd0);
    chk("rst_wb_rdata", wb_rdata, 32'd0);
    chk("rst_wb_alu", wb_alu, 32'd0);
    chk("rst_wb_reg", 32'(wb_reg), 32'd0);
    reset = 1'b0;

    // ALU op
    run_instr(5'b00010, 32'h1234, 5'd7, 32'h0, 0, 32'h0);
    chk("alu_wb_ctr", 32'(wb_ctr), 32'h2);
    chk("alu_wb_alu", wb_alu, 32'h1234);
    chk("alu_wb_reg", 32'(wb_reg), 32'd7);
    chk("alu_stall_cycles", 32'(stall_cycles), 32'd0);

    // Load, ready in third WAIT cycle
    run_instr(5'b01011, 32'h100, 5'd9, 32'h0, 3, 32'hDEAD_BEEF);
    chk("ld_stall_cycles", 32'(stall_cycles), 32'd4);
    chk("ld_addr", seen_addr, 32'h100);
    chk("ld_we", 32'(seen_we), 32'd0);
    chk("ld_wb_rdata", wb_rdata, 32'hDEAD_BEEF);
    chk("ld_wb_ctr", 32'(wb_ctr), 32'h3);

    // Store back-to-back with the load, ready on first WAIT cycle
    run_instr(5'b00100, 32'h200, 5'd3, 32'hCAFE, 1, 32'hFFFF_0000);
    chk("st_we", 32'(seen_we), 32'd1);
    chk("st_wdata", seen_wdata, 32'hCAFE);
    chk("st_stall_cycles", 32'(stall_cycles), 32'd2);
    chk("st_wb_ctr", 32'(wb_ctr), 32'd0);

    // Read+write together behaves as a write
    run_instr(5'b01111, 32'h300, 5'd4, 32'h55AA, 2, 32'h7777_7777);
    chk("rw_we", 32'(seen_we), 32'd1);
    chk("rw_wb_rdata", wb_rdata, 32'd0);

    // Branch taken / not taken
    zero = 1'b1; add_result = 32'h40;
    run_instr(5'b10000, 32'h0, 5'd0, 32'h0, 0, 32'h0);
    chk("br_pcsrc", 32'(pcsrc), 32'd1);
    chk("br_target", branch_target, 32'h40);
    zero = 1'b0;
    #1;
    chk("br_pcsrc_nz", 32'(pcsrc), 32'd0);
    run_instr(5'b10000, 32'h0, 5'd0, 32'h0, 0, 32'h0);

    // Misaligned load to 0x102
    run_instr(5'b01011, 32'h102, 5'd5, 32'h0, 1, 32'h0BAD_F00D);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_fault", 32'(align_fault), 32'd1);
    chk("mis_req_cycles", 32'(req_cycles), 32'd0);
    chk("mis_wb_ctr", 32'(wb_ctr), 32'd0);
    chk("mis_stall_cycles", 32'(stall_cycles), 32'd0);
`else
    chk("mis_addr", seen_addr, 32'h100);
    chk("mis_wb_rdata", wb_rdata, 32'h0BAD_F00D);
    chk("mis_fault", 32'(align_fault), 32'd0);
`endif

    // Reset asserted while the load is waiting
    ctr_bits = 5'b01011; alu_result = 32'h400; write_reg = 5'd12; rdata2 = '0;
    dmem_ready = 1'b0; dmem_rdata = 32'h9999_9999;
    stall_cycles = 0; req_cycles = 0;
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 2'b00, '0, '0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h400, '0, 2'b00, '0, '0, '0, 1'b0);
    reset = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 32'h400, '0, 2'b00, '0, '0, '0, 1'b0);
    reset = 1'b0;
    chk("rw_abort_req", 32'(dmem_req), 32'd0);
    chk("rw_abort_wb_ctr", 32'(wb_ctr), 32'd0);
    // Back in IDLE: a plain ALU op flows through without stall
    run_instr(5'b00010, 32'hABCD, 5'd2, 32'h0, 0, 32'h0);
    chk("post_rst_wb_alu", wb_alu, 32'hABCD);
    chk("post_rst_stall", 32'(stall_cycles), 32'd0);

    // Trailing idle cycle so the last write-back is also compared by the model
    run_instr(5'b00000, 32'h0, 5'd0, 32'h0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
